mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Shares one N x N combinational multiplier between two independent requesters.
- Arbitration is round-robin. The product is returned through a registered response port with valid/ready backpressure and a requester tag.
- Sits between the DSP filter/MAC front-ends and the shared multiplier datapath, which it instantiates internally.
- Also keeps per-requester grant counters for throughput profiling.

Parameters:
- N, 4: operand width. Product width is 2N.
- CW, 16: width of each grant counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  N  requester 0 operand A (unsigned)
- req0_b  in  N  requester 0 operand B (unsigned)
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a  in  N  requester 1 operand A (unsigned)
- req1_b  in  N  requester 1 operand B (unsigned)
- rsp_valid  out  1  response holds a product
- rsp_ready  in  1  downstream takes the response
- rsp_id  out  1  requester that owns the response (0/1)
- rsp_prod  out  2N  unsigned product A*B
- cnt_clear  in  1  synchronous clear of both grant counters
- grant_cnt0  out  CW  accepted requests from requester 0
- grant_cnt1  out  CW  accepted requests from requester 1

Behaviour:
- Reset: asserting rst_n low asynchronously forces these values.
  - rsp_valid=0, rsp_id=0, rsp_prod=0.
  - grant_cnt0=0, grant_cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
  - FSM=EMPTY.
- Reset mid-operation drops any held response; nothing is replayed.
- FSM states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- slot_free = (state==EMPTY) || rsp_ready. This is combinational.
- Grant (combinational):
  - Only req0 valid -> g0.
  - Only req1 valid -> g1.
  - Both valid -> the requester != last_grant.
  - Neither valid -> no grant.
- reqX_ready = slot_free && gX. At most one ready is high in any cycle. reqX_ready may depend on reqX_valid.
- Accept = a reqX_valid && reqX_ready handshake. On the accepting clk edge:
  - rsp_prod <= product of the granted operands, computed by the internal multiplier.
  - rsp_id <= X.
  - last_grant <= X.
  - state <= FULL.
- Latency: the product is visible on rsp_* the cycle after acceptance.
- Full throughput: with rsp_ready held high, one accept per cycle.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + rsp_ready + accept -> FULL, with the new data loaded in the same edge.
  - FULL + rsp_ready + no accept -> EMPTY.
  - FULL + !rsp_ready -> FULL. rsp_id and rsp_prod are held stable, and both readys are 0.
- last_grant changes only on accept. An idle cycle does not rotate priority.
- Arithmetic: unsigned, full 2N-bit result, no truncation. Max case (2^N-1)^2 must be exact.
- Counters:
  - grant_cntX increments by 1 on each requester-X accept.
  - Saturates at all-ones; no wrap.
  - cnt_clear forces both to 0 on the next edge. Clear wins over a same-cycle accept, so that accept is not counted.
- Requesters must hold valid and operands stable until ready. The block does not register operands before grant.

Test Plan:
- Reset then idle: rst_n low, clk toggling -> rsp_valid=0, both readys 0, counters 0. Release with no requests -> unchanged.
- Single request, N=4: req0 a=15, b=15 with rsp_ready=1 -> req0_ready=1 in that cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_prod=225. Following cycle rsp_valid=0, grant_cnt0=1.
- Contention round-robin: both valid every cycle, operands req0 (3,5) and req1 (7,9), rsp_ready=1 -> responses alternate id 0,1,0,1 with prods 15,63,15,63. One response per cycle. After 4 accepts both counters =2.
- Backpressure: req1 (12,11) accepted, rsp_ready=0 for 3 cycles while req0 is valid -> rsp held at id=1, prod=132. req0_ready=0 throughout. When rsp_ready=1, req0 is accepted in that same cycle and the next response is id 0.
- Counters: CW=2, 5 requester-0 accepts -> grant_cnt0 = 3 (saturated). cnt_clear asserted in the same cycle as an accept -> grant_cnt0 = 0 next cycle.
- Async reset mid-operation: rsp_valid=1 with id=1, rst_n pulsed low between edges -> outputs zero immediately. After release, req0 wins the first contention.

Source files
------------

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin share of one NxN multiplier between two requesters,
// with a registered valid/ready response port and saturating per-requester grant counters.
module mult_share_arb #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [N-1:0]    req0_a,
  input  logic [N-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [N-1:0]    req1_a,
  input  logic [N-1:0]    req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*N-1:0]  rsp_prod,
  input  logic            cnt_clear,
  output logic [CW-1:0]   grant_cnt0,
  output logic [CW-1:0]   grant_cnt1
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t         state, state_n;
  logic           last_grant, slot_free, g0, g1, acc0, acc1, acc;
  logic [N-1:0]   op_a, op_b;
  logic [2*N-1:0] prod;
  always_comb begin
    slot_free  = (state == EMPTY) || rsp_ready;
    // on contention the requester that did not win last time goes first
    g0         = req0_valid && (!req1_valid || last_grant);
    g1         = req1_valid && (!req0_valid || !last_grant);
    req0_ready = slot_free && g0;
    req1_ready = slot_free && g1;
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    acc        = acc0 || acc1;
    op_a       = g1 ? req1_a : req0_a;
    op_b       = g1 ? req1_b : req0_b;
    prod       = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  always_comb begin
    state_n = acc ? FULL : (state == FULL && rsp_ready) ? EMPTY : state;
  end
  always_comb begin
    rsp_valid = (state == FULL);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_prod   <= '0;
      last_grant <= 1'b1;
    end else if (acc) begin
      rsp_id     <= acc1;
      rsp_prod   <= prod;
      last_grant <= acc1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clear) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (acc0 && grant_cnt0 != {CW{1'b1}}) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (acc1 && grant_cnt1 != {CW{1'b1}}) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed checks of arbitration, latency, backpressure, counters and async reset.
module tb_mult_share_arb;
  localparam int N  = 4;
  localparam int CW = 2;
  logic          clk = 0, rst_n = 0;
  logic          req0_valid = 0, req1_valid = 0, rsp_ready = 0, cnt_clear = 0;
  logic          req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [N-1:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2*N-1:0] rsp_prod;
  logic [CW-1:0] grant_cnt0, grant_cnt1;
  int total = 0, bad = 0;

  mult_share_arb #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .cnt_clear(cnt_clear), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0; cnt_clear = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    total++; if ({grant_cnt0, grant_cnt1, rsp_id, rsp_prod} !== '0) begin bad++; $display("FAIL reset_regs cnt0=%0d cnt1=%0d id=%b prod=%0d exp all 0", grant_cnt0, grant_cnt1, rsp_id, rsp_prod); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    total++; if ({rsp_valid, req0_ready, req1_ready, grant_cnt0, grant_cnt1} !== '0) begin bad++; $display("FAIL idle_after_release valid=%b cnt0=%0d cnt1=%0d exp 0", rsp_valid, grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_single();
    req0_valid = 1; req0_a = 15; req0_b = 15; rsp_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b0, 8'd225}) begin bad++; $display("FAIL single_rsp valid=%b id=%b prod=%0d exp 1/0/225", rsp_valid, rsp_id, rsp_prod); end
    req0_valid = 0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || grant_cnt0 !== 2'd1) begin bad++; $display("FAIL single_after valid=%b cnt0=%0d exp 0/1", rsp_valid, grant_cnt0); end
  endtask

  task automatic test_contention();
    logic [7:0] ep;
    apply_reset();
    req0_valid = 1; req0_a = 3; req0_b = 5;
    req1_valid = 1; req1_a = 7; req1_b = 9; rsp_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL cont_first_ready got=%b exp=10", {req0_ready, req1_ready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ep = (i % 2 == 0) ? 8'd15 : 8'd63;
      total++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'(i % 2), ep}) begin bad++; $display("FAIL cont_rsp%0d valid=%b id=%b prod=%0d exp 1/%0d/%0d", i, rsp_valid, rsp_id, rsp_prod, i % 2, ep); end
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || grant_cnt0 !== 2'd2 || grant_cnt1 !== 2'd2) begin bad++; $display("FAIL cont_counts valid=%b cnt0=%0d cnt1=%0d exp 0/2/2", rsp_valid, grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_backpressure();
    req1_valid = 1; req1_a = 12; req1_b = 11; rsp_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_accept_ready got=%b exp=01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_a = 2; req0_b = 3; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({rsp_valid, rsp_id, rsp_prod, req0_ready, req1_ready} !== {1'b1, 1'b1, 8'd132, 2'b00}) begin bad++; $display("FAIL bp_hold%0d valid=%b id=%b prod=%0d rdy=%b%b exp 1/1/132/00", i, rsp_valid, rsp_id, rsp_prod, req0_ready, req1_ready); end
      if (i < 2) @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", req0_ready); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b0, 8'd6}) begin bad++; $display("FAIL bp_next_rsp valid=%b id=%b prod=%0d exp 1/0/6", rsp_valid, rsp_id, rsp_prod); end
    req0_valid = 0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain valid=%b exp=0", rsp_valid); end
  endtask

  task automatic test_counters();
    cnt_clear = 1;
    @(negedge clk);
    cnt_clear = 0;
    total++; if (grant_cnt0 !== 2'd0 || grant_cnt1 !== 2'd0) begin bad++; $display("FAIL cnt_clear_idle cnt0=%0d cnt1=%0d exp 0/0", grant_cnt0, grant_cnt1); end
    req0_valid = 1; req0_a = 1; req0_b = 1; rsp_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (grant_cnt0 !== 2'((k > 3) ? 3 : k)) begin bad++; $display("FAIL cnt_sat%0d got=%0d exp=%0d", k, grant_cnt0, (k > 3) ? 3 : k); end
    end
    cnt_clear = 1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL cnt_clear_acc_ready got=%b exp=1", req0_ready); end
    @(negedge clk);
    total++; if (grant_cnt0 !== 2'd0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL cnt_clear_wins cnt0=%0d valid=%b exp 0/1", grant_cnt0, rsp_valid); end
    cnt_clear = 0; req0_valid = 0;
    @(negedge clk);
    total++; if (grant_cnt0 !== 2'd0) begin bad++; $display("FAIL cnt_after_clear got=%0d exp=0", grant_cnt0); end
  endtask

  task automatic test_async_reset();
    req0_valid = 1; req0_a = 4; req0_b = 5;
    req1_valid = 1; req1_a = 6; req1_b = 7; rsp_ready = 0;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b1, 8'd42}) begin bad++; $display("FAIL ar_pre valid=%b id=%b prod=%0d exp 1/1/42", rsp_valid, rsp_id, rsp_prod); end
    #1 rst_n = 0;
    #1;
    total++; if ({rsp_valid, rsp_id, rsp_prod, grant_cnt0, grant_cnt1} !== '0) begin bad++; $display("FAIL ar_zero valid=%b id=%b prod=%0d cnt1=%0d exp 0", rsp_valid, rsp_id, rsp_prod, grant_cnt1); end
    #1 rst_n = 1; rsp_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL ar_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b0, 8'd20}) begin bad++; $display("FAIL ar_rsp valid=%b id=%b prod=%0d exp 1/0/20", rsp_valid, rsp_id, rsp_prod); end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_counters();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
